ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//   PS/2 host-to-device transmitter. It is the opposite direction of the keyboard receive path
//   in the audio/keyboard controller. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset)
//   to the device on the shared ps2_clk/ps2_data open-drain lines.
//   It sits beside the PS/2 receiver in the top wrapper and is fed from the CPU's memory-mapped IO write path.
// PARAMETERS
//   INHIBIT_CYCLES  5000    clock-low inhibit time before request (100 us at 50 MHz)
//   TIMEOUT_CYCLES  750000  watchdog, reloaded on every device clock fall (15 ms at 50 MHz)
// PORTS
//   clock        in   1  system clock (50 MHz PLL output); all logic on posedge
//   reset        in   1  synchronous, active-low: reset==0 on a posedge resets all state
//   tx_valid     in   1  command byte present
//   tx_data      in   8  command byte
//   tx_ready     out  1  high when IDLE; transfer accepted on tx_valid & tx_ready
//   ps2_clk_in   in   1  raw pad level of ps2_clk (asynchronous)
//   ps2_data_in  in   1  raw pad level of ps2_data (asynchronous)
//   ps2_clk_oe   out  1  1 = pull ps2_clk low; wrapper drives pad = oe ? 1'b0 : 1'bz
//   ps2_data_oe  out  1  1 = pull ps2_data low; same open-drain rule
//   rx_inhibit   out  1  high whenever not IDLE; receiver ignores the lines meanwhile
//   done         out  1  one-cycle pulse when a frame completes or aborts
//   ack_ok       out  1  valid with done: 1 = device acked (data low on 11th fall)
//   err          out  1  valid with done: 1 = watchdog expired or no ack
// BEHAVIOUR
//   Reset values: tx_ready=1, both oe=0, rx_inhibit=0, done=0, ack_ok=0, err=0, state=IDLE.
//   Reset mid-frame releases both lines on that same edge. There is no partial-frame recovery.
//   Inputs pass through a 2-FF synchroniser. fall = clk_s_prev & ~clk_s, so detection lags the pad by 3 cycles.
//   Frame: shift register {stop=1, parity=~^tx_data, tx_data[7:0]}, sent LSB first. Parity is odd.
//   The data line is "driven" by ps2_data_oe = ~bit.
//   States:
//    IDLE    tx_ready=1. On tx_valid: latch tx_data, clear counters -> INHIBIT.
//            tx_valid while not IDLE is ignored; the data is not latched.
//    INHIBIT clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles -> REQ.
//    REQ     clk_oe=1, data_oe=1 (start bit) for 1 cycle -> BITS. Watchdog is loaded here.
//    BITS    clk_oe=0 (clock released, device clocks). Start bit is held until the 1st fall.
//            Falls 1..8 present d0..d7, fall 9 presents parity, fall 10 presents stop (data released).
//            Each new bit is updated in the cycle after the fall is detected.
//            After fall 10 -> ACK.
//    ACK     both oe=0. On fall 11 sample data_s: ack_ok = ~data_s -> WAITREL.
//    WAITREL wait for clk_s=1 & data_s=1 -> IDLE with done=1.
//            err = ~ack_ok. Completion has no other check.
//   Watchdog: runs in REQ..WAITREL and reloads on every fall.
//            On expiry: release both oe, done=1, ack_ok=0, err=1 -> IDLE.
//   Simultaneous fall and watchdog expiry in the same cycle: the fall wins (counter reloaded).
//   Bit counter is 4 bits, range 0..11, and never wraps.
//   A fall seen in INHIBIT/REQ is our own clock pull, so it is ignored.
//   rx_inhibit = (state != IDLE); done is registered; tx_ready drops the cycle after acceptance.
//   Latency: accept -> clk_oe rise 1 cycle; one frame at 10-16.7 kHz device clock is ~1.1 ms.
// STRUCTURE
//   Shared package ps2_pkg:
//     - state encoding (IDLE, INHIBIT, REQ, BITS, ACK, WAITREL)
//     - odd-parity function
//     - frame length constant 11
//     - command constants CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF
//   Sub-module ps2_sync_edge: 2-FF synchroniser plus falling-edge pulse, one instance per line.
//   It is reused by the receiver.
// TESTING
//   Bench contains a PS/2 device model: 40 us clock period, samples data on rising edges,
//   and drives its ack low in the 11th clock low phase.
//   1 tx 8'hED -> clk_oe high exactly 5000 cycles, then start 0, bits 1,0,1,1,0,1,1,1,
//     parity 1, stop 1; ack -> done pulse, ack_ok=1, err=0.
//   2 tx 8'h01 -> model sees parity bit 0. tx 8'h00 -> parity bit 1. Bytes decode exactly.
//   3 model never toggles clock after REQ -> at 750000 cycles: done=1, err=1, both oe=0,
//     back to IDLE, tx_ready=1.
//   4 model omits ack (data stays high) -> done=1, ack_ok=0, err=1.
//   5 reset=0 asserted during bit 4 -> both oe=0 and tx_ready=1 on that edge;
//     next tx 8'hFF completes normally.
//   6 tx_valid pulsed with 8'h55 mid-frame of 8'hED -> ignored; only 0xED is observed, single done.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 definitions (FSM state codes, frame length, command bytes, parity helper)
package ps2_pkg;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_BITS    = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_WAITREL = 3'd5;
    localparam int FRAME_LEN = 11;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-FF synchroniser for one PS/2 pad plus falling-edge pulse
//   clock, reset (sync, active-low) ; pad (async raw level) ;
//   level (synchronised level) ; fall (one-cycle pulse on synchronised 1->0)
module ps2_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic pad,
    output logic level,
    output logic fall
);
    logic meta;
    logic prev;
    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious fall.
    always_ff @(posedge clock) begin
        if (!reset) begin
            meta  <= 1'b1;
            level <= 1'b1;
            prev  <= 1'b1;
        end else begin
            meta  <= pad;
            level <= meta;
            prev  <= level;
        end
    end
    assign fall = prev & ~level;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter on open-drain clk/data lines
//   clock, reset (sync, active-low)
//   tx_valid/tx_data/tx_ready : command byte handshake (accepted in IDLE)
//   ps2_clk_in/ps2_data_in    : raw pad levels ; ps2_clk_oe/ps2_data_oe : 1 = pull pad low
//   rx_inhibit : busy indication for the receiver ; done/ack_ok/err : completion pulse + status
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output logic       done,
    output logic       ack_ok,
    output logic       err
);
    localparam int TW = $clog2(INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1;

    logic [2:0]    state;
    logic [TW-1:0] tmr;
    logic [3:0]    cnt;
    logic [10:0]   shreg;
    logic          ack_r;
    logic          clk_s;
    logic          clk_fall;
    logic          data_s;
    logic          unused_data_fall;

    ps2_sync_edge u_clk (
        .clock (clock),
        .reset (reset),
        .pad   (ps2_clk_in),
        .level (clk_s),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_data (
        .clock (clock),
        .reset (reset),
        .pad   (ps2_data_in),
        .level (data_s),
        .fall  (unused_data_fall)
    );

    // tmr is the inhibit timer in INHIBIT and the watchdog from REQ onwards.
    // shreg[0] is the bit currently presented; it starts as the start bit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= S_IDLE;
            tmr    <= '0;
            cnt    <= '0;
            shreg  <= '1;
            ack_r  <= 1'b0;
            done   <= 1'b0;
            ack_ok <= 1'b0;
            err    <= 1'b0;
        end else begin
            done   <= 1'b0;
            ack_ok <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        shreg <= {1'b1, odd_parity(tx_data), tx_data, 1'b0};
                        tmr   <= '0;
                        cnt   <= '0;
                        ack_r <= 1'b0;
                        state <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (tmr == TW'(INHIBIT_CYCLES - 1)) state <= S_REQ;
                    else tmr <= tmr + TW'(1);
                end
                S_REQ: begin
                    tmr   <= TW'(TIMEOUT_CYCLES - 1);
                    state <= S_BITS;
                end
                S_BITS, S_ACK, S_WAITREL: begin
                    // A fall takes priority over an expiring watchdog.
                    if (clk_fall) begin
                        tmr <= TW'(TIMEOUT_CYCLES - 1);
                        if (cnt != 4'(FRAME_LEN)) cnt <= cnt + 4'd1;
                        if (state == S_BITS) begin
                            shreg <= {1'b1, shreg[10:1]};
                            if (cnt == 4'(FRAME_LEN - 2)) state <= S_ACK;
                        end else if (state == S_ACK) begin
                            ack_r <= ~data_s;
                            state <= S_WAITREL;
                        end
                    end else if (state == S_WAITREL && clk_s && data_s) begin
                        state  <= S_IDLE;
                        done   <= 1'b1;
                        ack_ok <= ack_r;
                        err    <= ~ack_r;
                    end else if (tmr == '0) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign tx_ready    = state == S_IDLE;
    assign rx_inhibit  = ~tx_ready;
    assign ps2_clk_oe  = state == S_INHIBIT || state == S_REQ;
    assign ps2_data_oe = (state == S_REQ || state == S_BITS) && !shreg[0];
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench with PS/2 device model and timeline scoreboard for ps2_host_tx
module tb_ps2_host_tx;
    localparam int N = 40;
    localparam int T = 1500;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit, done, ack_ok, err;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_pad, data_pad;

    assign clk_pad  = ~(ps2_clk_oe | dev_clk_low);
    assign data_pad = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(N), .TIMEOUT_CYCLES(T)) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (clk_pad),
        .ps2_data_in (data_pad),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .rx_inhibit  (rx_inhibit),
        .done        (done),
        .ack_ok      (ack_ok),
        .err         (err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc = 0;
    int m_end = -1;
    int m_mode = 0;
    int ndone = 0;
    bit m_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        return {1'b1, ($countones(b) % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    // Model: accept happens on a posedge with tx_valid while idle; reset forgets the frame.
    initial forever begin
        @(posedge clock);
        cyc++;
        if (!reset) begin
            m_busy = 1'b0;
            m_end = -1;
        end else if (tx_valid && !m_busy) begin
            m_busy = 1'b1;
            acc = cyc;
            m_end = -1;
        end
    end

    // Timeline after accept: N cycles clock pull, 1 cycle request, then clock released until done.
    initial forever begin
        int k;
        @(negedge clock);
        k = cyc - acc;
        if (done) begin
            if (!m_busy) check("done_unexpected", 1, 0);
            else begin
                if (m_mode == 1) check("timeout_window", (k >= N + T && k <= N + T + 2), 1);
                else check("end_window", (m_end >= 0 && cyc - m_end >= 1 && cyc - m_end <= 5), 1);
                check("ack_ok", ack_ok, m_mode == 0);
                check("err", err, m_mode != 0);
                m_busy = 1'b0;
                ndone++;
            end
        end
        if (!m_busy) begin
            check("ready_idle", tx_ready, 1);
            check("inhibit_idle", rx_inhibit, 0);
            check("clk_oe_idle", ps2_clk_oe, 0);
            check("data_oe_idle", ps2_data_oe, 0);
        end else begin
            check("ready_busy", tx_ready, 0);
            check("inhibit_busy", rx_inhibit, 1);
            if (k < N) begin
                check("clk_oe_inhibit", ps2_clk_oe, 1);
                check("data_oe_inhibit", ps2_data_oe, 0);
            end else if (k == N) begin
                check("clk_oe_req", ps2_clk_oe, 1);
                check("data_oe_req", ps2_data_oe, 1);
            end else begin
                check("clk_oe_bits", ps2_clk_oe, 0);
            end
        end
    end

    // Device: waits for the request, then clocks nclk periods; reads data before each rise.
    task automatic dev(input int nclk, input bit do_ack, input int h, output logic [9:0] got);
        int w1;
        int w2;
        got = '0;
        w1 = 0;
        while (clk_pad !== 1'b0 && w1 < 5000) begin @(negedge clock); w1++; end
        w2 = 0;
        while (!(clk_pad === 1'b1 && data_pad === 1'b0) && w2 < 5000) begin @(negedge clock); w2++; end
        check("request_seen", (w1 < 5000 && w2 < 5000), 1);
        repeat (5) @(negedge clock);
        for (int i = 0; i < nclk; i++) begin
            dev_clk_low = 1'b1;
            if (i == 10 && do_ack) dev_data_low = 1'b1;
            repeat (h) @(negedge clock);
            if (i < 10) got[i] = data_pad;
            dev_clk_low = 1'b0;
            dev_data_low = 1'b0;
            if (i == nclk - 1) m_end = cyc;
            repeat (h) @(negedge clock);
        end
    endtask

    task automatic wait_idle(input int limit);
        int w;
        w = 0;
        while (m_busy && w < limit) begin @(negedge clock); w++; end
        check("idle_reached", m_busy, 0);
    endtask

    task automatic send(input logic [7:0] b);
        wait_idle(5000);
        @(negedge clock);
        tx_data = b;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] b, input int mode, input int h, output logic [9:0] got);
        m_mode = mode;
        send(b);
        dev(11, mode == 0, h, got);
        wait_idle(200);
    endtask

    initial begin
        logic [9:0] got;
        logic [7:0] b;
        int h;
        int d0;
        repeat (3) @(negedge clock);
        check("rst_ready", tx_ready, 1);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_inhibit", rx_inhibit, 0);
        check("rst_done", done, 0);
        check("rst_ack_ok", ack_ok, 0);
        check("rst_err", err, 0);
        reset = 1'b1;
        @(negedge clock);

        frame(8'hED, 0, 20, got);
        check("frame_ed", got, 10'h3ED);
        frame(8'h01, 0, 20, got);
        check("frame_01", got, 10'h201);
        frame(8'h00, 0, 20, got);
        check("frame_00", got, 10'h300);

        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            h = int'($urandom_range(12, 25));
            repeat (int'($urandom_range(0, 30))) @(negedge clock);
            frame(b, (i == 2) ? 2 : 0, h, got);
            check("frame_rand", got, exp_frame(b));
        end

        m_mode = 1;
        send(8'hA5);
        dev(0, 1'b0, 20, got);
        wait_idle(N + T + 100);
        check("timeout_ready", tx_ready, 1);

        frame(8'h3C, 2, 18, got);
        check("frame_noack", got, exp_frame(8'h3C));

        m_mode = 0;
        send(8'hED);
        dev(4, 1'b1, 20, got);
        check("partial_bits", got[3:0], 4'hD);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_clk_oe", ps2_clk_oe, 0);
        check("midrst_data_oe", ps2_data_oe, 0);
        check("midrst_ready", tx_ready, 1);
        reset = 1'b1;
        @(negedge clock);
        frame(8'hFF, 0, 20, got);
        check("frame_ff", got, 10'h3FF);

        m_mode = 0;
        d0 = ndone;
        send(8'hED);
        fork
            dev(11, 1'b1, 20, got);
            begin
                repeat (N + 200) @(negedge clock);
                tx_data = 8'h55;
                tx_valid = 1'b1;
                @(negedge clock);
                tx_valid = 1'b0;
            end
        join
        wait_idle(200);
        repeat (20) @(negedge clock);
        check("ignored_frame", got, 10'h3ED);
        check("single_done", ndone - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
